// File: rtl/if_fetch_unit_if.sv
// Fetch-unit bundle: instruction-memory request/response channel, redirect
// input and the {pc, instruction} handshake toward the ID stage.
interface if_fetch_unit_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instruction;
  logic        id_ready;

  modport master (
    input  redirect, redirect_pc, inst_addr_ok, inst_data_ok, inst_rdata, id_ready,
    output inst_req, inst_addr, id_valid, id_pc, id_instruction
  );

  modport slave (
    output redirect, redirect_pc, inst_addr_ok, inst_data_ok, inst_rdata, id_ready,
    input  inst_req, inst_addr, id_valid, id_pc, id_instruction
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues credit-limited word requests,
// tags returned words with their PC in an in-order queue and flushes on redirect.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          QDEPTH   = 2
) (
  input logic            clk,
  input logic            resetn,
  if_fetch_unit_if.master bus
);
  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [CNT_W:0]   DEPTH = (CNT_W + 1)'(QDEPTH);
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(QDEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;
  state_t state, state_nxt;

  logic [31:0]      pc_r;
  logic [31:0]      pend_pc;
  logic             redirect_pend;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] discard;
  logic [CNT_W-1:0] out_nxt;

  logic [31:0]      pf_pc [QDEPTH];
  logic [PTR_W-1:0] pf_rd, pf_wr;

  logic [31:0]      q_pc   [QDEPTH];
  logic [31:0]      q_inst [QDEPTH];
  logic [PTR_W-1:0] q_rd, q_wr;
  logic [CNT_W-1:0] q_count;

  logic        credit, req, accept, rsp, drop, late_stale;
  logic        q_push, q_pop, id_valid_w;
  logic [31:0] target;
  logic        unused_bits;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Redirect targets are word aligned; the low two bits are dropped on purpose.
  assign target      = {bus.redirect_pc[31:2], 2'b00};
  assign unused_bits = ^bus.redirect_pc[1:0];

  assign credit = ({1'b0, outstanding} + {1'b0, q_count}) < DEPTH;

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: begin
        req = credit;
        if (credit && !bus.inst_addr_ok) state_nxt = S_HOLD;
      end
      S_HOLD: begin
        req = 1'b1;
        if (bus.inst_addr_ok) state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign accept     = req && bus.inst_addr_ok;
  assign rsp        = bus.inst_data_ok;
  assign drop       = rsp && (discard != '0);
  assign late_stale = accept && (state == S_HOLD) && redirect_pend;
  assign out_nxt    = outstanding + CNT_W'(accept) - CNT_W'(rsp);

  assign bus.inst_req  = req;
  assign bus.inst_addr = pc_r;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state         <= S_IDLE;
      pc_r          <= RESET_PC;
      redirect_pend <= 1'b0;
      outstanding   <= '0;
      discard       <= '0;
      pf_rd         <= '0;
      pf_wr         <= '0;
    end else begin
      state       <= state_nxt;
      outstanding <= out_nxt;
      if (accept) pf_wr <= ptr_inc(pf_wr);
      if (rsp)    pf_rd <= ptr_inc(pf_rd);
      // Every accepted, unreturned request at a redirect becomes stale.
      if (bus.redirect) discard <= out_nxt;
      else              discard <= discard - CNT_W'(drop) + CNT_W'(late_stale);
      if (bus.redirect && state != S_HOLD) begin
        pc_r <= target;
      end else if (accept) begin
        if (state == S_HOLD && bus.redirect) pc_r <= target;
        else if (redirect_pend)              pc_r <= pend_pc;
        else                                 pc_r <= pc_r + 32'd4;
        redirect_pend <= 1'b0;
      end else if (bus.redirect) begin
        redirect_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.redirect && state == S_HOLD) pend_pc <= target;
    if (accept) pf_pc[pf_wr] <= pc_r;
  end

  // Response queue toward ID.
  assign q_push = rsp && (discard == '0) && !bus.redirect;
  assign q_pop  = id_valid_w && bus.id_ready && !bus.redirect;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      q_rd    <= '0;
      q_wr    <= '0;
      q_count <= '0;
    end else if (bus.redirect) begin
      q_rd    <= '0;
      q_wr    <= '0;
      q_count <= '0;
    end else begin
      if (q_push) q_wr <= ptr_inc(q_wr);
      if (q_pop)  q_rd <= ptr_inc(q_rd);
      q_count <= q_count + CNT_W'(q_push) - CNT_W'(q_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (q_push) begin
      q_pc[q_wr]   <= pf_pc[pf_rd];
      q_inst[q_wr] <= bus.inst_rdata;
    end
  end

  assign id_valid_w         = (q_count != '0);
  assign bus.id_valid       = id_valid_w;
  assign bus.id_pc          = id_valid_w ? q_pc[q_rd]   : '0;
  assign bus.id_instruction = id_valid_w ? q_inst[q_rd] : '0;

  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !(q_push && !q_pop && q_count == CNT_W'(QDEPTH)));
  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!resetn)
    !(rsp && outstanding == '0));
endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: an in-order memory model plus a reference
// model of which accepted words must reach ID and what the next address must be.
module tb_if_fetch_unit;
  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam int          QDEPTH   = 2;

  logic clk = 1'b0;
  logic resetn;
  if_fetch_unit_if bus();

  if_fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] pc; logic [31:0] inst; } exp_t;
  typedef struct { logic [31:0] addr; int due; } mem_t;

  exp_t sb[$];
  mem_t mem_q[$];
  int checks, errors, cyc, lat, n_pop, n_acc, max_inflight;
  logic in_hold, skip_next;
  logic [31:0] hold_addr, pend_pc, exp_addr, last_pop_pc, last_acc;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[31:16]};
  endfunction

  // Model the coming clock edge from settled values, then advance one cycle.
  task automatic step();
    logic acc;
    logic [31:0] a;
    exp_t e;
    @(negedge clk);
    acc = bus.inst_req && bus.inst_addr_ok;
    a   = bus.inst_addr;
    if (!resetn) begin
      sb.delete(); mem_q.delete();
      in_hold = 0; skip_next = 0; exp_addr = RESET_PC;
    end else begin
      if (in_hold) begin
        checks++;
        if (bus.inst_req !== 1'b1 || a !== hold_addr) begin
          errors++;
          $display("FAIL hold_stable: req=%0b addr=%h required req=1 addr=%h", bus.inst_req, a, hold_addr);
        end
      end
      if (bus.inst_data_ok && mem_q.size() > 0) void'(mem_q.pop_front());
      if (bus.id_valid && bus.id_ready && !bus.redirect) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL id_unexpected: pc=%h inst=%h required no valid word", bus.id_pc, bus.id_instruction);
        end else begin
          e = sb.pop_front();
          if (bus.id_pc !== e.pc || bus.id_instruction !== e.inst) begin
            errors++;
            $display("FAIL id_word: pc=%h inst=%h required pc=%h inst=%h", bus.id_pc, bus.id_instruction, e.pc, e.inst);
          end
        end
        n_pop++;
        last_pop_pc = bus.id_pc;
      end
      if (acc) begin
        checks++;
        if (a !== exp_addr) begin
          errors++;
          $display("FAIL req_addr: got %h required %h", a, exp_addr);
        end
        mem_q.push_back('{addr: a, due: cyc + lat});
        if (mem_q.size() > max_inflight) max_inflight = mem_q.size();
        n_acc++;
        last_acc = a;
      end
      if (bus.redirect) begin
        sb.delete();
        if (in_hold && !acc) begin
          skip_next = 1;
          pend_pc   = {bus.redirect_pc[31:2], 2'b00};
        end else begin
          exp_addr = {bus.redirect_pc[31:2], 2'b00};
        end
      end else if (acc) begin
        if (skip_next) begin
          skip_next = 0;
          exp_addr  = pend_pc;
        end else begin
          sb.push_back('{pc: a, inst: word(a)});
          exp_addr = a + 32'd4;
        end
      end
      in_hold = bus.inst_req && !bus.inst_addr_ok;
      if (in_hold) hold_addr = a;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      bus.inst_data_ok = 1'b1;
      bus.inst_rdata   = word(mem_q[0].addr);
    end else begin
      bus.inst_data_ok = 1'b0;
      bus.inst_rdata   = 32'h0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (bus.inst_req !== 1'b0 || bus.inst_addr !== RESET_PC || bus.id_valid !== 1'b0 ||
        bus.id_pc !== 32'h0 || bus.id_instruction !== 32'h0) begin
      errors++;
      $display("FAIL %s: req=%0b addr=%h valid=%0b pc=%h inst=%h required 0/%h/0/0/0", tag,
               bus.inst_req, bus.inst_addr, bus.id_valid, bus.id_pc, bus.id_instruction, RESET_PC);
    end
  endtask

  task automatic wait_pop(input string tag, input logic [31:0] want);
    int p0, k;
    p0 = n_pop; k = 0;
    while (n_pop == p0 && k < 40) begin step(); k++; end
    checks++;
    if (n_pop == p0 || last_pop_pc !== want) begin
      errors++;
      $display("FAIL %s: popped=%0d pc=%h required pc=%h", tag, n_pop - p0, last_pop_pc, want);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    step(); step();
    check_reset_outputs("reset_state");
    resetn = 1'b1;
  endtask

  task automatic test_stream();
    int p0;
    bus.inst_addr_ok = 1'b1; bus.id_ready = 1'b1; lat = 1;
    p0 = n_pop;
    repeat (30) step();
    checks++;
    if (n_pop - p0 < 15) begin
      errors++;
      $display("FAIL stream_rate: got %0d words required >= 15", n_pop - p0);
    end
    checks++;
    if (last_pop_pc !== RESET_PC + 32'(4 * (n_pop - 1))) begin
      errors++;
      $display("FAIL stream_pc: got %h required %h", last_pop_pc, RESET_PC + 32'(4 * (n_pop - 1)));
    end
  endtask

  task automatic test_backpressure();
    int p0;
    bus.id_ready = 1'b0; max_inflight = 0;
    repeat (10) step();
    checks++;
    if (bus.inst_req !== 1'b0 || bus.id_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_full: req=%0b valid=%0b required req=0 valid=1", bus.inst_req, bus.id_valid);
    end
    checks++;
    if (max_inflight > QDEPTH) begin
      errors++;
      $display("FAIL bp_inflight: got %0d required <= %0d", max_inflight, QDEPTH);
    end
    p0 = n_pop; bus.id_ready = 1'b1;
    repeat (6) step();
    checks++;
    if (n_pop - p0 < 2) begin
      errors++;
      $display("FAIL bp_drain: got %0d words required >= 2", n_pop - p0);
    end
  endtask

  task automatic test_redirect_outstanding();
    int k;
    lat = 4; bus.id_ready = 1'b1; bus.inst_addr_ok = 1'b1;
    k = 0;
    while (!(mem_q.size() == 2 && !bus.inst_data_ok) && k < 40) begin step(); k++; end
    checks++;
    if (mem_q.size() != 2) begin
      errors++;
      $display("FAIL redir_setup: outstanding=%0d required 2", mem_q.size());
    end
    bus.redirect = 1'b1; bus.redirect_pc = 32'h8000_1002;
    step();
    bus.redirect = 1'b0;
    checks++;
    if (bus.id_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_flush: valid=%0b required 0", bus.id_valid);
    end
    lat = 1; k = 0;
    while (bus.inst_req !== 1'b1 && k < 20) begin step(); k++; end
    checks++;
    if (bus.inst_req !== 1'b1 || bus.inst_addr !== 32'h8000_1000) begin
      errors++;
      $display("FAIL redir_addr: req=%0b addr=%h required req=1 addr=80001000", bus.inst_req, bus.inst_addr);
    end
    wait_pop("redir_first_pc", 32'h8000_1000);
  endtask

  task automatic test_hold_redirect();
    int k;
    logic [31:0] a0;
    bus.id_ready = 1'b1; lat = 1; bus.inst_addr_ok = 1'b0;
    k = 0;
    while (bus.inst_req !== 1'b1 && k < 20) begin step(); k++; end
    a0 = bus.inst_addr;
    step();
    checks++;
    if (bus.inst_req !== 1'b1 || bus.inst_addr !== a0) begin
      errors++;
      $display("FAIL hold_enter: req=%0b addr=%h required req=1 addr=%h", bus.inst_req, bus.inst_addr, a0);
    end
    bus.redirect = 1'b1; bus.redirect_pc = 32'h8000_4000;
    step();
    bus.redirect = 1'b0;
    checks++;
    if (bus.inst_req !== 1'b1 || bus.inst_addr !== a0) begin
      errors++;
      $display("FAIL hold_after_redirect: req=%0b addr=%h required req=1 addr=%h", bus.inst_req, bus.inst_addr, a0);
    end
    step();
    bus.inst_addr_ok = 1'b1;
    step();
    checks++;
    if (bus.inst_addr !== 32'h8000_4000) begin
      errors++;
      $display("FAIL hold_next_addr: got %h required 80004000", bus.inst_addr);
    end
    wait_pop("hold_first_pc", 32'h8000_4000);
  endtask

  task automatic test_same_cycle();
    int k;
    bus.inst_addr_ok = 1'b1; bus.id_ready = 1'b0; lat = 1;
    k = 0;
    while (!(bus.id_valid && bus.inst_data_ok) && k < 30) begin step(); k++; end
    checks++;
    if (!(bus.id_valid && bus.inst_data_ok)) begin
      errors++;
      $display("FAIL same_setup: valid=%0b data_ok=%0b required both 1", bus.id_valid, bus.inst_data_ok);
    end
    bus.id_ready = 1'b1; bus.redirect = 1'b1; bus.redirect_pc = 32'h8000_8008;
    step();
    bus.redirect = 1'b0;
    checks++;
    if (bus.id_valid !== 1'b0) begin
      errors++;
      $display("FAIL same_flush: valid=%0b required 0", bus.id_valid);
    end
    wait_pop("same_first_pc", 32'h8000_8008);
    wait_pop("same_second_pc", 32'h8000_800C);
  endtask

  task automatic test_wrap_and_reset();
    int k;
    bus.id_ready = 1'b1; bus.inst_addr_ok = 1'b1; lat = 1;
    bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
    step();
    bus.redirect = 1'b0;
    k = 0;
    while (last_acc !== 32'hFFFF_FFFC && k < 20) begin step(); k++; end
    checks++;
    if (last_acc !== 32'hFFFF_FFFC || bus.inst_addr !== 32'h0) begin
      errors++;
      $display("FAIL wrap_addr: accepted=%h next=%h required FFFFFFFC then 00000000", last_acc, bus.inst_addr);
    end
    wait_pop("wrap_pop_top", 32'hFFFF_FFFC);
    wait_pop("wrap_pop_zero", 32'h0);
    resetn = 1'b0;
    step();
    check_reset_outputs("midstream_reset");
    resetn = 1'b1;
    wait_pop("reset_recover", RESET_PC);
  endtask

  initial begin
    resetn = 1'b0;
    bus.redirect = 1'b0; bus.redirect_pc = 32'h0;
    bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = 32'h0;
    bus.id_ready = 1'b0;
    checks = 0; errors = 0; cyc = 0; lat = 1; n_pop = 0; n_acc = 0; max_inflight = 0;
    in_hold = 0; skip_next = 0; hold_addr = 0; pend_pc = 0; exp_addr = RESET_PC;
    last_pop_pc = 0; last_acc = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_outstanding();
    test_hold_redirect();
    test_same_cycle();
    test_wrap_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
